// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: UART (8N1) command port that peeks/pokes 32-bit words on the
// mem_valid/mem_ready bus. Commands: 'W' addr[4] data[4] -> 0x06,
// 'R' addr[4] -> rdata[4], anything else or a bus timeout -> 0x15.
// Optional build macro UART_BRIDGE_AUTOINC_EN adds the 'w'/'r' opcodes, which
// reuse a persistent address register that advances by 4 after every success.
module uart_mem_bridge #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int BUS_TIMEOUT  = 1024,
    parameter int IDLE_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        bus_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam int BTW = $clog2(BUS_TIMEOUT + 1);
    localparam int ITW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BTW-1:0] BUS_LAST  = BTW'(BUS_TIMEOUT - 1);
    localparam logic [ITW-1:0] IDLE_LAST = ITW'(IDLE_TIMEOUT - 1);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
`ifdef UART_BRIDGE_AUTOINC_EN
    localparam logic [7:0] OP_WRITE_INC = 8'h77;
    localparam logic [7:0] OP_READ_INC  = 8'h72;
`endif
    localparam logic [7:0] REPLY_ACK = 8'h06;
    localparam logic [7:0] REPLY_NAK = 8'h15;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t      rx_state_reg;
    logic           rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [BCW-1:0] rx_cnt_reg;
    logic [2:0]     rx_bit_reg;
    logic [7:0]     rx_shift_reg;
    logic [7:0]     rx_data_reg;
    logic           rx_strobe_reg;
    logic           rx_ferr_reg;

    // Synchronise the line, detect a start edge, sample mid-bit, validate the stop bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_reg   <= 1'b1;
            rx_sync_reg   <= 1'b1;
            rx_prev_reg   <= 1'b1;
            rx_state_reg  <= RX_IDLE;
            rx_cnt_reg    <= '0;
            rx_bit_reg    <= '0;
            rx_shift_reg  <= '0;
            rx_data_reg   <= '0;
            rx_strobe_reg <= 1'b0;
            rx_ferr_reg   <= 1'b0;
        end else begin
            rx_meta_reg   <= uart_rx;
            rx_sync_reg   <= rx_meta_reg;
            rx_prev_reg   <= rx_sync_reg;
            rx_strobe_reg <= 1'b0;
            rx_ferr_reg   <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    // Edge (not level) so a line stuck low after a framing error cannot retrigger.
                    if (rx_prev_reg && !rx_sync_reg) begin
                        rx_state_reg <= RX_START;
                        rx_cnt_reg   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_reg == HALF_LAST) begin
                        rx_cnt_reg <= '0;
                        if (rx_sync_reg) begin
                            rx_state_reg <= RX_IDLE;
                        end else begin
                            rx_state_reg <= RX_DATA;
                            rx_bit_reg   <= '0;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + BCW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                        if (rx_bit_reg == 3'd7) begin
                            rx_state_reg <= RX_STOP;
                        end else begin
                            rx_bit_reg <= rx_bit_reg + 3'd1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + BCW'(1);
                    end
                end
                default: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_state_reg <= RX_IDLE;
                        rx_cnt_reg   <= '0;
                        if (rx_sync_reg) begin
                            rx_data_reg   <= rx_shift_reg;
                            rx_strobe_reg <= 1'b1;
                        end else begin
                            rx_ferr_reg <= 1'b1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + BCW'(1);
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic           tx_line_reg;
    logic           tx_busy_reg;
    logic [BCW-1:0] tx_cnt_reg;
    logic [3:0]     tx_idx_reg;
    logic [8:0]     tx_shift_reg;
    logic           tx_done;
    logic           tx_ready;
    logic           tx_load;
    logic [7:0]     tx_byte;

    // The final stop-bit cycle counts as free so the next reply byte starts without a gap.
    assign tx_done  = tx_busy_reg && (tx_idx_reg == 4'd9) && (tx_cnt_reg == BIT_LAST);
    assign tx_ready = !tx_busy_reg || tx_done;

    // Shift start, 8 data bits LSB first, stop; reset forces the line idle-high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_line_reg  <= 1'b1;
            tx_busy_reg  <= 1'b0;
            tx_cnt_reg   <= '0;
            tx_idx_reg   <= '0;
            tx_shift_reg <= '0;
        end else if (tx_load) begin
            tx_line_reg  <= 1'b0;
            tx_shift_reg <= {1'b1, tx_byte};
            tx_busy_reg  <= 1'b1;
            tx_cnt_reg   <= '0;
            tx_idx_reg   <= '0;
        end else if (tx_busy_reg) begin
            if (tx_cnt_reg == BIT_LAST) begin
                tx_cnt_reg <= '0;
                if (tx_idx_reg == 4'd9) begin
                    tx_busy_reg <= 1'b0;
                    tx_line_reg <= 1'b1;
                end else begin
                    tx_line_reg  <= tx_shift_reg[0];
                    tx_shift_reg <= {1'b1, tx_shift_reg[8:1]};
                    tx_idx_reg   <= tx_idx_reg + 4'd1;
                end
            end else begin
                tx_cnt_reg <= tx_cnt_reg + BCW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Command FSM and bus initiator
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_RESP, S_NAK} state_t;

    state_t         state_reg;
    logic           is_write_reg;
    logic [1:0]     fld_cnt_reg;
    logic [31:0]    field_reg;
    logic [31:0]    field_next;
    logic [31:0]    addr_reg;
    logic [31:0]    wdata_reg;
    logic [3:0]     wstrb_reg;
    logic [31:0]    rdata_reg;
    logic           valid_reg;
    logic           bus_err_reg;
    logic [BTW-1:0] bus_cnt_reg;
    logic [ITW-1:0] idle_cnt_reg;
    logic [2:0]     resp_idx_reg;
    logic [2:0]     resp_len_reg;
    logic [7:0]     rdata_bytes [4];

    // Little-endian field assembly: each new byte enters at the top.
    assign field_next = {rx_data_reg, field_reg[31:8]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_rdata_bytes
        assign rdata_bytes[gi] = rdata_reg[8*gi +: 8];
    end

    assign tx_load = tx_ready && ((state_reg == S_RESP) || (state_reg == S_NAK))
                     && (resp_idx_reg != resp_len_reg);

    // Reply byte for the current response slot.
    always_comb begin
        tx_byte = REPLY_NAK;
        if (state_reg == S_RESP) begin
            tx_byte = is_write_reg ? REPLY_ACK : rdata_bytes[resp_idx_reg[1:0]];
        end
    end

    // Command decoding, field collection, bus handshake and reply sequencing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_IDLE;
            is_write_reg <= 1'b0;
            fld_cnt_reg  <= '0;
            field_reg    <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            rdata_reg    <= '0;
            valid_reg    <= 1'b0;
            bus_err_reg  <= 1'b0;
            bus_cnt_reg  <= '0;
            idle_cnt_reg <= '0;
            resp_idx_reg <= '0;
            resp_len_reg <= '0;
        end else begin
            bus_err_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (rx_strobe_reg) begin
                        fld_cnt_reg  <= '0;
                        idle_cnt_reg <= '0;
                        case (rx_data_reg)
                            OP_WRITE: begin
                                state_reg    <= S_ADDR;
                                is_write_reg <= 1'b1;
                            end
                            OP_READ: begin
                                state_reg    <= S_ADDR;
                                is_write_reg <= 1'b0;
                            end
`ifdef UART_BRIDGE_AUTOINC_EN
                            OP_WRITE_INC: begin
                                state_reg    <= S_WDATA;
                                is_write_reg <= 1'b1;
                            end
                            OP_READ_INC: begin
                                state_reg    <= S_BUS;
                                is_write_reg <= 1'b0;
                                wstrb_reg    <= 4'h0;
                                bus_cnt_reg  <= '0;
                            end
`endif
                            default: begin
                                state_reg    <= S_NAK;
                                resp_idx_reg <= '0;
                                resp_len_reg <= 3'd1;
                            end
                        endcase
                    end
                end
                S_ADDR, S_WDATA: begin
                    if (rx_strobe_reg) begin
                        field_reg    <= field_next;
                        idle_cnt_reg <= '0;
                        fld_cnt_reg  <= fld_cnt_reg + 2'd1;
                        if (fld_cnt_reg == 2'd3) begin
                            if (state_reg == S_ADDR) begin
                                addr_reg <= field_next;
                                if (is_write_reg) begin
                                    state_reg <= S_WDATA;
                                end else begin
                                    state_reg   <= S_BUS;
                                    wstrb_reg   <= 4'h0;
                                    bus_cnt_reg <= '0;
                                end
                            end else begin
                                wdata_reg   <= field_next;
                                state_reg   <= S_BUS;
                                wstrb_reg   <= 4'hF;
                                bus_cnt_reg <= '0;
                            end
                        end
                    end else if (rx_ferr_reg || (idle_cnt_reg == IDLE_LAST)) begin
                        // Broken or stalled command: drop it without a reply.
                        state_reg <= S_IDLE;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + ITW'(1);
                    end
                end
                S_BUS: begin
                    if (!valid_reg) begin
                        valid_reg <= 1'b1;
                    end else if (mem_ready) begin
                        // Ready wins even on the final timeout cycle.
                        valid_reg    <= 1'b0;
                        rdata_reg    <= mem_rdata;
                        state_reg    <= S_RESP;
                        resp_idx_reg <= '0;
                        resp_len_reg <= is_write_reg ? 3'd1 : 3'd4;
`ifdef UART_BRIDGE_AUTOINC_EN
                        addr_reg     <= addr_reg + 32'd4;
`endif
                    end else if (bus_cnt_reg == BUS_LAST) begin
                        valid_reg    <= 1'b0;
                        bus_err_reg  <= 1'b1;
                        state_reg    <= S_NAK;
                        resp_idx_reg <= '0;
                        resp_len_reg <= 3'd1;
                    end else begin
                        bus_cnt_reg <= bus_cnt_reg + BTW'(1);
                    end
                end
                default: begin
                    // S_RESP / S_NAK: feed reply bytes, leave once the last stop bit ends.
                    if (tx_load) begin
                        resp_idx_reg <= resp_idx_reg + 3'd1;
                    end
                    if ((resp_idx_reg == resp_len_reg) && tx_done) begin
                        state_reg <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign uart_tx   = tx_line_reg;
    assign mem_valid = valid_reg;
    assign mem_instr = 1'b0;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_wstrb = wstrb_reg;
    assign busy      = (state_reg != S_IDLE);
    assign bus_err   = bus_err_reg;

endmodule
